// File: rtl/nibble_io_bridge.sv
`default_nettype none
// ============================================================================
// nibble_io_bridge : pad-side nibble stream <-> core-side word bridge (RX/TX)
// Rev 1.0
// ============================================================================
module nibble_io_bridge #(
   parameter int WORD_W = 16,
   parameter int NIB_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NIB_W-1:0]  DIN,
   input  logic              DIN_VLD,
   output logic              DIN_RDY,
   output logic [WORD_W-1:0] WORD_OUT,
   output logic              WORD_VLD,
   input  logic              WORD_RDY,
   input  logic [WORD_W-1:0] WORD_IN,
   input  logic              WORD_IN_VLD,
   output logic              WORD_IN_RDY,
   output logic [NIB_W-1:0]  DOUT,
   output logic              DOUT_VLD,
   input  logic              DOUT_RDY
);
   localparam int N  = WORD_W / NIB_W;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam int ASM_W = WORD_W - NIB_W;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} tx_state_t;

   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [ASM_W-1:0]  asm_q, asm_d;
   logic [WORD_W-1:0] word_out_q, word_out_d;
   logic              word_vld_q, word_vld_d;
   logic              rx_last, din_fire;

   tx_state_t         state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [NIB_W-1:0]  dout_q, dout_d;
   logic              dout_vld_q, dout_vld_d;

   assign rx_last     = (rx_cnt_q == LAST);
   assign DIN_RDY     = !RST && !(rx_last && word_vld_q && !WORD_RDY);
   assign din_fire    = DIN_VLD && DIN_RDY;
   assign WORD_IN_RDY = !RST && (state_q == S_IDLE);

   assign WORD_OUT = word_out_q;
   assign WORD_VLD = word_vld_q;
   assign DOUT     = dout_q;
   assign DOUT_VLD = dout_vld_q;

   // Only slots 0..N-2 are buffered; the final nibble goes straight into WORD_OUT.
   always_comb begin
      rx_cnt_d   = rx_cnt_q;
      asm_d      = asm_q;
      word_out_d = word_out_q;
      word_vld_d = word_vld_q;
      if (word_vld_q && WORD_RDY) begin
         word_vld_d = 1'b0;
      end
      if (din_fire) begin
         if (rx_last) begin
            word_out_d = {DIN, asm_q};
            word_vld_d = 1'b1;
            rx_cnt_d   = '0;
         end else begin
            for (int k = 0; k < N - 1; k++) begin
               if (rx_cnt_q == CW'(k)) begin
                  asm_d[k*NIB_W +: NIB_W] = DIN;
               end
            end
            rx_cnt_d = rx_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      tx_cnt_d = tx_cnt_q;
      if (state_q == S_IDLE) begin
         if (WORD_IN_VLD && WORD_IN_RDY) begin
            shreg_d  = WORD_IN;
            tx_cnt_d = '0;
            state_d  = S_SEND;
         end
      end else if (DOUT_RDY) begin
         shreg_d  = shreg_q >> NIB_W;
         tx_cnt_d = tx_cnt_q + 1'b1;
         if (tx_cnt_q == LAST) begin
            state_d = S_IDLE;
         end
      end
      // Output nibble is pre-computed from next state so DOUT/DOUT_VLD stay registered.
      dout_vld_d = (state_d == S_SEND);
      dout_d     = dout_vld_d ? shreg_d[NIB_W-1:0] : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_cnt_q   <= '0;
         asm_q      <= '0;
         word_out_q <= '0;
         word_vld_q <= 1'b0;
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         tx_cnt_q   <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         asm_q      <= asm_d;
         word_out_q <= word_out_d;
         word_vld_q <= word_vld_d;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         tx_cnt_q   <= tx_cnt_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
      end
   end

endmodule
`default_nettype wire
